register_command_issuer: RTL

Command-side driver for the 16-bit function register (FunSel/E/I/Q interface: 000 decrement, 001 increment, 010 load, 011 clear).
- Accepts queued commands over a valid/ready handshake and expands each into the exact FunSel/E/I cycle sequence the register needs.
- Reports completion, and optionally checks the register's Q against a shadow model.
- Sits between the control unit and any register instance.

---
 rtl/register_cmd_pkg.sv | 37 +++
 rtl/register_command_issuer_if.sv | 31 +++
 rtl/register_cmd_fifo.sv | 59 +++++
 rtl/register_command_issuer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/register_cmd_pkg.sv
// Shared types and constants for the register command issuer.
//   FS_*        : FunSel codes understood by the 16-bit function register
//   state_e     : issuer FSM states
//   cmd_t       : one queued command {funsel, data, count}
//   next_shadow : expected register value after a command, modulo 2^16
package register_cmd_pkg;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StSettle
  } state_e;

  typedef struct packed {
    logic [2:0]  funsel;
    logic [15:0] data;
    logic [7:0]  count;
  } cmd_t;

  // count N means N+1 steps for inc/dec; wrap-around is intentional.
  function automatic logic [15:0] next_shadow(logic [15:0] q, cmd_t cmd);
    logic [15:0] steps;
    steps = {8'h00, cmd.count} + 16'd1;
    case (cmd.funsel)
      FS_DEC:  next_shadow = q - steps;
      FS_INC:  next_shadow = q + steps;
      FS_LOAD: next_shadow = cmd.data;
      default: next_shadow = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/register_command_issuer_if.sv
// Command handshake bundle between the control unit (master) and the issuer (slave).
//   cmd_valid  : command offered
//   cmd_ready  : issuer can accept a command this cycle
//   cmd_funsel : requested register function
//   cmd_data   : load value
//   cmd_count  : repeat count for inc/dec (N means N+1 operations)
interface register_command_issuer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_funsel;
  logic [15:0] cmd_data;
  logic [7:0]  cmd_count;

  modport master (
    output cmd_valid,
    output cmd_funsel,
    output cmd_data,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_funsel,
    input  cmd_data,
    input  cmd_count,
    output cmd_ready
  );

endinterface

// File: rtl/register_cmd_fifo.sv
// Synchronous command FIFO, no bypass (a write is visible on the read side one edge later).
//   clk_i, rst_i : clock, asynchronous active-high reset (flushes the FIFO)
//   push_i       : write wdata_i when not full
//   pop_i        : drop head entry when not empty
//   rdata_o      : head entry
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
module register_cmd_fifo
  import register_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  cmd_t wdata_i,
  input  logic pop_i,
  output cmd_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/register_command_issuer.sv
// Command-side driver for a 16-bit function register (FunSel/E/I/Q).
// Queues commands and expands each into the FunSel/E/I cycle burst the register needs.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   cmd_if        : command handshake (slave side)
//   fun_sel_o     : register FunSel   (registered)
//   e_o           : register enable   (registered)
//   i_o           : register load bus (registered)
//   q_i           : register output, fed back
//   busy_o        : FIFO non-empty or FSM not idle
//   done_o        : one-cycle pulse per completed command
//   illegal_cmd_o : one-cycle pulse when a 1xx command is dropped
//   error_o       : sticky readback mismatch
// Build option: define READBACK_CHECK_EN to compare Q against a shadow model in SETTLE;
// otherwise error_o is tied low and timing is identical.
module register_command_issuer
  import register_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  register_command_issuer_if.slave  cmd_if,
  output logic [2:0]                fun_sel_o,
  output logic                      e_o,
  output logic [15:0]               i_o,
  input  logic [15:0]               q_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      illegal_cmd_o,
  output logic                      error_o
);

  cmd_t        push_cmd, head;
  logic        full, empty, pop;
  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  fun_sel_q;
  logic        e_q, done_q, illegal_q;
  logic [15:0] i_q;

  assign push_cmd         = {cmd_if.cmd_funsel, cmd_if.cmd_data, cmd_if.cmd_count};
  assign cmd_if.cmd_ready = !full && !rst_i;
  assign pop              = (state_q == StIdle) && !empty;

  register_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_if.cmd_valid),
    .wdata_i (push_cmd),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      fun_sel_q <= FS_DEC;
      e_q       <= 1'b0;
      i_q       <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            if (head.funsel[2]) begin
              illegal_q <= 1'b1;
            end else begin
              state_q   <= StIssue;
              e_q       <= 1'b1;
              fun_sel_q <= head.funsel;
              i_q       <= (head.funsel == FS_LOAD) ? head.data : 16'h0000;
              // Load and clear (funsel[1] set) are single-shot regardless of count.
              cnt_q     <= head.funsel[1] ? 8'd0 : head.count;
            end
          end
        end
        StIssue: begin
          if (cnt_q == 8'd0) begin
            state_q   <= StSettle;
            e_q       <= 1'b0;
            fun_sel_q <= FS_DEC;
            i_q       <= '0;
            done_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StSettle: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

`ifdef READBACK_CHECK_EN
  logic [15:0] shadow_q;
  logic        error_q;

  // Shadow holds the value Q must show in SETTLE, computed from Q at pop time.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      error_q  <= 1'b0;
    end else begin
      if (pop && !head.funsel[2]) shadow_q <= next_shadow(q_i, head);
      if (state_q == StSettle && q_i != shadow_q) error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  logic unused_q_parity;
  assign unused_q_parity = ^q_i;
  assign error_o         = 1'b0;
`endif

  assign fun_sel_o     = fun_sel_q;
  assign e_o           = e_q;
  assign i_o           = i_q;
  assign done_o        = done_q;
  assign illegal_cmd_o = illegal_q;
  assign busy_o        = !empty || (state_q != StIdle);

endmodule
